cache_mem_bridge: RTL and testbench

Moves whole cache lines between the cache data array and main RAM on behalf of the cache controller. Sits directly downstream of the controller: it executes the controller's write-back-to-RAM and fetch-from-RAM steps word by word over a req/ack RAM port. It reports completion with a one-cycle `done` pulse.

---
 rtl/cache_bridge_pkg.sv | 23 ++
 rtl/bridge_watchdog.sv | 35 +++
 rtl/cache_mem_bridge.sv | 173 +++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bridge_pkg.sv
// Shared definitions for the cache <-> RAM line bridge.
// Holds the bridge state encoding, the cmd_op encodings and the helper that
// derives the word-offset width from the line size.
package cache_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_WB     = 2'b10;
  localparam logic [1:0] OP_WBFILL = 2'b11;

  // Word-offset width for a power-of-two line of `words` words.
  function automatic int unsigned calc_off_w(input int unsigned words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/bridge_watchdog.sv
// RAM-ack wait watchdog for cache_mem_bridge.
// Counts consecutive cycles in which a RAM request is outstanding without an
// ack; the count restarts on every ack and whenever no request is active,
// which also covers each state entry of the bridge.
// Ports:
//   clk, clr    : clock, synchronous active-high reset
//   req, ack    : RAM request and acknowledge of the bridge
//   expired_c   : high in the wait cycle that reaches LIMIT (combinational)
module bridge_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] wait_q;

  // Wait counter; the bridge leaves its access state on expiry, so no saturation is needed.
  always_ff @(posedge clk) begin
    if (clr || !req || ack) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + CNT_W'(1);
    end
  end

  // This wait cycle is the LIMIT-th one in a row.
  assign expired_c = req && !ack && (wait_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/cache_mem_bridge.sv
// Moves whole cache lines between the cache data array and main RAM.
// Executes write-back (array -> RAM), fill (RAM -> array) or both in sequence,
// one word per acknowledged RAM access, offsets ascending, then pulses done.
// Optional macro CACHE_BRIDGE_TIMEOUT_EN adds an ack-wait watchdog that aborts
// the command with err=1 after TIMEOUT_CYC wait cycles on one word.
// Ports:
//   clk, clr                          : clock, synchronous active-high reset
//   cmd_valid/op/wb_line/fill_line    : command from the cache controller
//   cmd_ready                         : high only while idle
//   done, err                         : one-cycle completion pulse, timeout qualifier
//   arr_idx/arr_rdata/arr_we/arr_wdata: cache data array word port
//   ram_req/we/addr/wdata/ack/rdata   : RAM word port, req held until ack
module cache_mem_bridge
  import cache_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned OFF_W      = calc_off_w(LINE_WORDS),
  localparam int unsigned LINE_W     = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [LINE_W-1:0] cmd_wb_line,
  input  logic [LINE_W-1:0] cmd_fill_line,
  output logic              cmd_ready,
  output logic              done,
  output logic              err,
  output logic [OFF_W-1:0]  arr_idx,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;
  logic [LINE_W-1:0] fill_line_q, fill_line_d;
  logic [LINE_W-1:0] line_sel;
  logic              expired_c;

  // State and command registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      wb_line_q   <= '0;
      fill_line_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      wb_line_q   <= wb_line_d;
      fill_line_q <= fill_line_d;
    end
  end

  // Next state and port controls; arr_we follows ram_ack in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    wb_line_d   = wb_line_q;
    fill_line_d = fill_line_q;
    line_sel    = '0;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    ram_req     = 1'b0;
    ram_we      = 1'b0;
    arr_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d        = cmd_op;
          wb_line_d   = cmd_wb_line;
          fill_line_d = cmd_fill_line;
          cnt_d       = '0;
          case (cmd_op)
            OP_WB, OP_WBFILL: state_d = ST_WB;
            OP_FILL:          state_d = ST_FILL;
            OP_NOP:           state_d = ST_DONE;
          endcase
        end
      end
      ST_WB: begin
        ram_req  = 1'b1;
        ram_we   = 1'b1;
        line_sel = wb_line_q;
        if (ram_ack) begin
          // Wraps to 0 at the line end, so a following fill starts at offset 0.
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = (op_q == OP_WBFILL) ? ST_FILL : ST_DONE;
          end
        end else if (expired_c) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        ram_req  = 1'b1;
        line_sel = fill_line_q;
        arr_we   = ram_ack;
        if (ram_ack) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end else if (expired_c) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign arr_idx   = cnt_q;
  assign ram_addr  = {line_sel, cnt_q};
  assign ram_wdata = arr_rdata;
  assign arr_wdata = ram_rdata;

`ifdef CACHE_BRIDGE_TIMEOUT_EN
  logic err_q;

  bridge_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .clr       (clr),
    .req       (ram_req),
    .ack       (ram_ack),
    .expired_c (expired_c)
  );

  // err is set on the abort edge so it coincides with the done pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      err_q <= 1'b0;
    end else if (expired_c) begin
      err_q <= 1'b1;
    end else if (state_q == ST_DONE) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign expired_c = 1'b0;
  // Constant 0; TIMEOUT_CYC has no effect without the watchdog.
  assign err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Self-checking bench for cache_mem_bridge: a queue of expected RAM accesses
// per command is the reference; a negedge process compares every cycle.
module tb_cache_mem_bridge;
  import cache_bridge_pkg::*;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned TO_CYC     = 8;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned LINE_W     = ADDR_W - OFF_W;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [LINE_W-1:0] cmd_wb_line = '0;
  logic [LINE_W-1:0] cmd_fill_line = '0;
  logic              cmd_ready, done, err, arr_we, ram_req, ram_we;
  logic [OFF_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_rdata, arr_wdata, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ack = 1'b0;
  logic [DATA_W-1:0] ram_rdata = '0;

  logic [DATA_W-1:0] arr_mem [LINE_WORDS];
  assign arr_rdata = arr_mem[arr_idx];

  always #5 clk = ~clk;

  cache_mem_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_wb_line(cmd_wb_line), .cmd_fill_line(cmd_fill_line), .cmd_ready(cmd_ready),
    .done(done), .err(err), .arr_idx(arr_idx), .arr_rdata(arr_rdata), .arr_we(arr_we),
    .arr_wdata(arr_wdata), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata)
  );

  // Reference: pending accesses {we, addr}, plus idle/done flags.
  logic [ADDR_W:0] exp_q[$];
  bit m_idle = 1'b1, m_done = 1'b0, m_err = 1'b0;
  int m_wait = 0;

  int checks = 0, failures = 0;
  bit run_chk = 1'b0;
  int lat_cnt = 0, last_lat = -1, done_cnt = 0, req_cycles = 0;
  bit last_err = 1'b0;
  logic [ADDR_W:0] seen[$];
  int ack_mode = 0;
  bit noise = 1'b0, hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference update on each clock edge.
  always @(posedge clk) begin
    if (clr) begin
      exp_q.delete();
      m_idle = 1'b1; m_done = 1'b0; m_err = 1'b0; m_wait = 0;
    end else if (m_done) begin
      m_done = 1'b0; m_err = 1'b0; m_idle = 1'b1;
    end else if (exp_q.size() != 0) begin
      if (ram_ack) begin
        void'(exp_q.pop_front());
        m_wait = 0;
        if (exp_q.size() == 0) m_done = 1'b1;
      end else begin
        m_wait++;
`ifdef CACHE_BRIDGE_TIMEOUT_EN
        if (m_wait == int'(TO_CYC)) begin
          exp_q.delete(); m_done = 1'b1; m_err = 1'b1; m_wait = 0;
        end
`endif
      end
    end else if (m_idle && cmd_valid) begin
      m_idle = 1'b0; m_wait = 0; lat_cnt = 0;
      if (cmd_op[1]) for (int w = 0; w < int'(LINE_WORDS); w++) exp_q.push_back({1'b1, cmd_wb_line, OFF_W'(w)});
      if (cmd_op[0]) for (int w = 0; w < int'(LINE_WORDS); w++) exp_q.push_back({1'b0, cmd_fill_line, OFF_W'(w)});
      if (exp_q.size() == 0) m_done = 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (run_chk) begin
      lat_cnt++;
      chk("cmd_ready", 32'(cmd_ready), 32'(m_idle));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_done && m_err));
      if (!m_done && exp_q.size() != 0) begin
        chk("ram_req", 32'(ram_req), 1);
        chk("ram_we", 32'(ram_we), 32'(exp_q[0][ADDR_W]));
        chk("ram_addr", 32'(ram_addr), 32'(exp_q[0][ADDR_W-1:0]));
        chk("arr_idx", 32'(arr_idx), 32'(exp_q[0][OFF_W-1:0]));
        if (exp_q[0][ADDR_W]) begin
          chk("ram_wdata", 32'(ram_wdata), 32'(arr_mem[exp_q[0][OFF_W-1:0]]));
          chk("arr_we_wb", 32'(arr_we), 0);
        end else begin
          chk("arr_we_fill", 32'(arr_we), 32'(ram_ack));
          if (ram_ack) chk("arr_wdata", 32'(arr_wdata), 32'(ram_rdata));
        end
        if (ram_ack) seen.push_back({ram_we, ram_addr});
      end else begin
        chk("ram_req_off", 32'(ram_req), 0);
        chk("arr_we_off", 32'(arr_we), 0);
      end
      if (ram_req) req_cycles++;
      if (done) begin last_lat = lat_cnt; last_err = err; done_cnt++; end
    end
  end

  // Advance one cycle and drive this cycle's inputs.
  task automatic tick();
    @(posedge clk); #1;
    ram_rdata = DATA_W'($urandom);
    case (ack_mode)
      0:       ram_ack = 1'b1;
      1:       ram_ack = (m_wait == 2);
      2:       ram_ack = 1'($urandom_range(0, 1));
      default: ram_ack = 1'b0;
    endcase
    if (!hold) cmd_valid = (noise && !m_idle) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noise) begin
      cmd_op        = 2'($urandom);
      cmd_wb_line   = LINE_W'($urandom);
      cmd_fill_line = LINE_W'($urandom);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [LINE_W-1:0] wb,
                         input logic [LINE_W-1:0] fl, input int mode, input int budget,
                         output int lat);
    int n = 0;
    for (int i = 0; i < int'(LINE_WORDS); i++) arr_mem[i] = DATA_W'($urandom);
    ack_mode = mode;
    tick();
    seen.delete(); req_cycles = 0; last_lat = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_wb_line = wb; cmd_fill_line = fl;
    tick();
    while (!m_idle && n < budget) begin tick(); n++; end
    if (!m_idle) begin
      chk("cmd_budget", 32'(m_idle), 1);
      clr = 1'b1; tick(); clr = 1'b0;
    end
    lat = last_lat;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int lat;
    int dc;
    for (int i = 0; i < int'(LINE_WORDS); i++) arr_mem[i] = '0;
    clr = 1'b1;
    tick(); tick();
    run_chk = 1'b1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ram_req", 32'(ram_req), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_arr_we", 32'(arr_we), 0);
    chk("rst_arr_idx", 32'(arr_idx), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    clr = 1'b0;

    // Fill line 0x0A5, zero-wait ack.
    run_cmd(OP_FILL, '0, LINE_W'(14'h0A5), 0, 40, lat);
    chk("fill_lat", 32'(lat), 5);
    chk("fill_nwords", 32'(seen.size()), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("fill_addr", 32'(seen[i]), 32'h0294 + 32'(i));

    // Writeback line 0x010, two wait cycles per word.
    run_cmd(OP_WB, LINE_W'(14'h010), '0, 1, 60, lat);
    chk("wb_lat", 32'(lat), 13);
    chk("wb_nwords", 32'(seen.size()), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("wb_addr", 32'(seen[i]), 32'h10040 + 32'(i));

    // Writeback-then-fill, no bubble between lines.
    run_cmd(OP_WBFILL, LINE_W'(14'h001), LINE_W'(14'h002), 0, 40, lat);
    chk("wbfill_lat", 32'(lat), 9);
    chk("wbfill_nwords", 32'(seen.size()), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      chk("wbfill_addr", 32'(seen[i]), (i < 4) ? (32'h10004 + 32'(i)) : (32'h00008 + 32'(i - 4)));

    // Nop.
    run_cmd(OP_NOP, '0, '0, 0, 10, lat);
    chk("nop_lat", 32'(lat), 1);
    chk("nop_req_cycles", 32'(req_cycles), 0);

    // Nop with cmd_valid held: accepted only on idle cycles.
    tick();
    hold = 1'b1; cmd_valid = 1'b1; cmd_op = OP_NOP; done_cnt = 0;
    repeat (5) tick();
    @(negedge clk); #1;
    chk("hold_done_cnt", 32'(done_cnt), 3);
    hold = 1'b0; cmd_valid = 1'b0;
    tick(); tick();

    // Reset after the second fill word.
    ack_mode = 0;
    tick();
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_fill_line = LINE_W'(14'h123);
    tick(); tick(); tick();
    clr = 1'b1;
    dc = done_cnt;
    tick();
    clr = 1'b0;
    @(negedge clk); #1;
    chk("clr_ram_req", 32'(ram_req), 0);
    chk("clr_arr_we", 32'(arr_we), 0);
    chk("clr_cmd_ready", 32'(cmd_ready), 1);
    tick(); tick(); tick();
    chk("clr_no_done", 32'(done_cnt), 32'(dc));

    // Ack never arrives.
`ifdef CACHE_BRIDGE_TIMEOUT_EN
    run_cmd(OP_FILL, '0, LINE_W'(14'h055), 3, 40, lat);
    chk("timeout_lat", 32'(lat), 9);
    chk("timeout_err", 32'(last_err), 1);
`else
    ack_mode = 3;
    tick();
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_fill_line = LINE_W'(14'h055);
    dc = done_cnt;
    tick();
    repeat (30) tick();
    @(negedge clk); #1;
    chk("noack_ram_req", 32'(ram_req), 1);
    chk("noack_no_done", 32'(done_cnt), 32'(dc));
    tick(); clr = 1'b1; tick(); clr = 1'b0;
`endif

    // Randomized commands, random ack, command noise while busy.
    noise = 1'b1;
    for (int k = 0; k < 40; k++)
      run_cmd(2'($urandom), LINE_W'($urandom), LINE_W'($urandom), 2, 300, lat);
    noise = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
